// File: rtl/apb_sl_mem.sv
// rtl/apb_sl_mem.sv - APB completer with word-addressed memory and per-byte written-tracking
module apb_sl_mem #(
  parameter int DATA_WIDTH  = 32,
  parameter int ADDR_WIDTH  = 8,
  parameter int DEPTH       = 200,
  parameter int WAIT_STATES = 0
) (
  input  logic                    pclk,
  input  logic                    presetn,
  input  logic                    psel,
  input  logic                    penable,
  input  logic                    pwrite,
  input  logic [ADDR_WIDTH-1:0]   paddr,
  input  logic [DATA_WIDTH-1:0]   pwdata,
  input  logic [DATA_WIDTH/8-1:0] pstrb,
  output logic [DATA_WIDTH-1:0]   prdata,
  output logic                    pready,
  output logic                    pslverr
);

  localparam int NB = DATA_WIDTH / 8;
  localparam int IW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  typedef enum logic [1:0] {S_IDLE, S_WAIT, S_DONE} state_t;

  state_t                  state_q, state_d;
  logic [3:0]              cnt_q, cnt_d;
  logic [ADDR_WIDTH-1:0]   addr_q, addr_d;
  logic                    write_q, write_d;
  logic [DATA_WIDTH-1:0]   wdata_q, wdata_d;
  logic [NB-1:0]           strb_q, strb_d;
  logic                    err_q, err_d;
  logic [DATA_WIDTH-1:0]   prdata_q, prdata_d;
  logic                    pready_q, pready_d;
  logic                    pslverr_q, pslverr_d;

  logic [DATA_WIDTH-1:0]   mem_q [DEPTH];
  logic [NB-1:0]           vld_q [DEPTH];

  logic [ADDR_WIDTH-1:0]   cur_addr;
  logic [IW-1:0]           cur_idx;
  logic [IW-1:0]           wr_idx;
  logic                    in_range;
  logic                    all_vld;
  logic                    err_new;
  logic [DATA_WIDTH-1:0]   rd_word;
  logic                    commit;

  // In IDLE the lookup uses the live bus; afterwards the captured address.
  always_comb begin
    cur_addr = (state_q == S_IDLE) ? paddr : addr_q;
    cur_idx  = cur_addr[IW-1:0];
    wr_idx   = addr_q[IW-1:0];
    in_range = (32'(cur_addr) < DEPTH);
    all_vld  = in_range && (&vld_q[cur_idx]);
    err_new  = !in_range || (!pwrite && !all_vld);
    rd_word  = in_range ? mem_q[cur_idx] : '0;
  end

  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q;
    addr_d    = addr_q;
    write_d   = write_q;
    wdata_d   = wdata_q;
    strb_d    = strb_q;
    err_d     = err_q;
    prdata_d  = prdata_q;
    pready_d  = 1'b0;
    pslverr_d = 1'b0;
    commit    = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (psel && !penable) begin
          addr_d  = paddr;
          write_d = pwrite;
          wdata_d = pwdata;
          strb_d  = pstrb;
          err_d   = err_new;
          if (WAIT_STATES == 0) begin
            state_d   = S_DONE;
            pready_d  = 1'b1;
            pslverr_d = err_new;
            if (!pwrite) prdata_d = err_new ? '0 : rd_word;
          end else begin
            state_d = S_WAIT;
            cnt_d   = 4'(WAIT_STATES);
          end
        end
      end
      S_WAIT: begin
        if (!psel) begin
          state_d = S_IDLE;
          cnt_d   = 4'd0;
        end else if (penable) begin
          if (cnt_q == 4'd1) begin
            state_d   = S_DONE;
            cnt_d     = 4'd0;
            pready_d  = 1'b1;
            pslverr_d = err_q;
            if (!write_q) prdata_d = err_q ? '0 : rd_word;
          end else begin
            cnt_d = cnt_q - 4'd1;
          end
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
        commit  = psel && write_q && !err_q;
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pclk or negedge presetn) begin
    if (!presetn) begin
      state_q   <= S_IDLE;
      cnt_q     <= 4'd0;
      addr_q    <= '0;
      write_q   <= 1'b0;
      wdata_q   <= '0;
      strb_q    <= '0;
      err_q     <= 1'b0;
      prdata_q  <= '0;
      pready_q  <= 1'b0;
      pslverr_q <= 1'b0;
      for (int w = 0; w < DEPTH; w++) vld_q[w] <= '0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      addr_q    <= addr_d;
      write_q   <= write_d;
      wdata_q   <= wdata_d;
      strb_q    <= strb_d;
      err_q     <= err_d;
      prdata_q  <= prdata_d;
      pready_q  <= pready_d;
      pslverr_q <= pslverr_d;
      if (commit) begin
        for (int i = 0; i < NB; i++) begin
          if (strb_q[i]) vld_q[wr_idx][i] <= 1'b1;
        end
      end
    end
  end

  // Memory contents are deliberately left out of reset.
  always_ff @(posedge pclk) begin
    if (commit) begin
      for (int i = 0; i < NB; i++) begin
        if (strb_q[i]) mem_q[wr_idx][i*8 +: 8] <= wdata_q[i*8 +: 8];
      end
    end
  end

  assign prdata  = prdata_q;
  assign pready  = pready_q;
  assign pslverr = pslverr_q;

endmodule

// File: tb/tb_apb_sl_mem.sv
// tb/tb_apb_sl_mem.sv - table-driven bench for apb_sl_mem, with 2 and 0 wait states
module tb_apb_sl_mem;

  logic        pclk = 1'b0;
  logic        presetn;
  logic        psel, penable, pwrite, use_b;
  logic [7:0]  paddr;
  logic [31:0] pwdata;
  logic [3:0]  pstrb;
  logic        psel_a, psel_b;
  logic [31:0] prdata_a, prdata_b;
  logic        pready_a, pready_b, pslverr_a, pslverr_b;

  int checks = 0;
  int errors = 0;

  typedef struct {
    bit          w;
    logic [7:0]  a;
    logic [31:0] d;
    logic [3:0]  s;
    logic        e;
    logic [31:0] rd;
  } vec_t;

  vec_t va[16];
  vec_t vb[4];

  assign psel_a = psel & ~use_b;
  assign psel_b = psel & use_b;

  apb_sl_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200), .WAIT_STATES(2)) dut_a (
    .pclk(pclk), .presetn(presetn), .psel(psel_a), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata_a), .pready(pready_a), .pslverr(pslverr_a));

  apb_sl_mem #(.DATA_WIDTH(32), .ADDR_WIDTH(8), .DEPTH(200), .WAIT_STATES(0)) dut_b (
    .pclk(pclk), .presetn(presetn), .psel(psel_b), .penable(penable), .pwrite(pwrite),
    .paddr(paddr), .pwdata(pwdata), .pstrb(pstrb),
    .prdata(prdata_b), .pready(pready_b), .pslverr(pslverr_b));

  always #5 pclk = ~pclk;

  function automatic logic rdy();
    return use_b ? pready_b : pready_a;
  endfunction

  function automatic logic serr();
    return use_b ? pslverr_b : pslverr_a;
  endfunction

  function automatic logic [31:0] rdat();
    return use_b ? prdata_b : prdata_a;
  endfunction

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%h expected=%h", name, act, exp);
    end
  endtask

  // Leaves psel high after completion so the next call is a back-to-back setup.
  task automatic xfer(input bit w, input logic [7:0] a, input logic [31:0] d,
                      input logic [3:0] s, output bit ok, output int cyc);
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = w; paddr = a; pwdata = d; pstrb = s;
    @(posedge pclk); #1;
    penable = 1'b1;
    cyc = 2;
    ok  = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge pclk);
      if (rdy()) begin
        ok = 1'b1;
        break;
      end
      @(posedge pclk); #1;
      cyc++;
    end
    if (!ok) begin
      check("xfer_timeout", 32'(ok), 32'd1);
      psel = 1'b0; penable = 1'b0;
    end
  endtask

  task automatic run_vec(input string tag, input vec_t v, input int exp_cyc);
    bit ok;
    int cyc;
    xfer(v.w, v.a, v.d, v.s, ok, cyc);
    if (ok) begin
      check({tag, "_cycles"}, 32'(cyc), 32'(exp_cyc));
      check({tag, "_pslverr"}, 32'(serr()), 32'(v.e));
      check({tag, "_prdata"}, rdat(), v.rd);
    end
  endtask

  task automatic idle();
    @(posedge pclk); #1;
    psel = 1'b0; penable = 1'b0;
  endtask

  initial begin
    #200000;
    $display("FAIL global_timeout actual=running required=finished");
    $fatal(1);
  end

  initial begin
    bit ok;
    int cyc;
    bit seen;

    va[0]  = '{1'b1, 8'h10, 32'hDEADBEEF, 4'hF, 1'b0, 32'h00000000};
    va[1]  = '{1'b0, 8'h10, 32'h0,        4'h0, 1'b0, 32'hDEADBEEF};
    va[2]  = '{1'b0, 8'h20, 32'h0,        4'h0, 1'b1, 32'h00000000};
    va[3]  = '{1'b1, 8'h20, 32'h000000AA, 4'h1, 1'b0, 32'h00000000};
    va[4]  = '{1'b0, 8'h20, 32'h0,        4'h0, 1'b1, 32'h00000000};
    va[5]  = '{1'b1, 8'h20, 32'h12345600, 4'hE, 1'b0, 32'h00000000};
    va[6]  = '{1'b0, 8'h20, 32'h0,        4'h0, 1'b0, 32'h123456AA};
    va[7]  = '{1'b1, 8'hC8, 32'h00000055, 4'hF, 1'b1, 32'h123456AA};
    va[8]  = '{1'b0, 8'hFF, 32'h0,        4'h0, 1'b1, 32'h00000000};
    va[9]  = '{1'b1, 8'hC7, 32'hA5A5A5A5, 4'hF, 1'b0, 32'h00000000};
    va[10] = '{1'b0, 8'hC7, 32'h0,        4'h0, 1'b0, 32'hA5A5A5A5};
    va[11] = '{1'b1, 8'h30, 32'hCAFEF00D, 4'hF, 1'b0, 32'hA5A5A5A5};
    va[12] = '{1'b1, 8'h31, 32'h00000000, 4'h0, 1'b0, 32'hA5A5A5A5};
    va[13] = '{1'b0, 8'h31, 32'h0,        4'h0, 1'b1, 32'h00000000};
    va[14] = '{1'b1, 8'h30, 32'hFFFFFFFF, 4'h0, 1'b0, 32'h00000000};
    va[15] = '{1'b0, 8'h30, 32'h0,        4'h0, 1'b0, 32'hCAFEF00D};

    vb[0] = '{1'b1, 8'h00, 32'h11223344, 4'hF, 1'b0, 32'h00000000};
    vb[1] = '{1'b1, 8'h01, 32'h55667788, 4'hF, 1'b0, 32'h00000000};
    vb[2] = '{1'b0, 8'h00, 32'h0,        4'h0, 1'b0, 32'h11223344};
    vb[3] = '{1'b0, 8'h01, 32'h0,        4'h0, 1'b0, 32'h55667788};

    presetn = 1'b0; psel = 1'b0; penable = 1'b0; pwrite = 1'b0; use_b = 1'b0;
    paddr = '0; pwdata = '0; pstrb = '0;
    #3;
    check("rst_prdata_a",  prdata_a,          32'h0);
    check("rst_pready_a",  32'(pready_a),     32'h0);
    check("rst_pslverr_a", 32'(pslverr_a),    32'h0);
    check("rst_outs_b",    {prdata_b[29:0], pready_b, pslverr_b}, 32'h0);
    @(posedge pclk); #1;
    presetn = 1'b1;

    for (int i = 0; i < 16; i++) run_vec($sformatf("va%0d", i), va[i], 4);
    idle();

    // Abort: psel dropped during the second wait cycle of a write.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b1; paddr = 8'h30; pwdata = 32'h11; pstrb = 4'hF;
    @(posedge pclk); #1;
    penable = 1'b1;
    seen = 1'b0;
    @(negedge pclk); seen |= pready_a;
    @(posedge pclk); #1;
    @(negedge pclk); seen |= pready_a;
    psel = 1'b0; penable = 1'b0;
    repeat (4) begin
      @(negedge pclk); seen |= pready_a;
    end
    check("abort_pready_seen", 32'(seen), 32'h0);
    xfer(1'b0, 8'h30, 32'h0, 4'h0, ok, cyc);
    if (ok) begin
      check("abort_read_prdata",  prdata_a,       32'hCAFEF00D);
      check("abort_read_pslverr", 32'(pslverr_a), 32'h0);
    end
    idle();

    // Reset asserted in the first wait cycle of a read of 0x10.
    @(posedge pclk); #1;
    psel = 1'b1; penable = 1'b0; pwrite = 1'b0; paddr = 8'h10;
    @(posedge pclk); #1;
    penable = 1'b1;
    @(negedge pclk); #1;
    presetn = 1'b0;
    #1;
    check("midrst_prdata",  prdata_a,       32'h0);
    check("midrst_pready",  32'(pready_a),  32'h0);
    check("midrst_pslverr", 32'(pslverr_a), 32'h0);
    psel = 1'b0; penable = 1'b0;
    @(posedge pclk); #1;
    presetn = 1'b1;
    xfer(1'b0, 8'h10, 32'h0, 4'h0, ok, cyc);
    if (ok) begin
      check("postrst_pslverr", 32'(pslverr_a), 32'h1);
      check("postrst_prdata",  prdata_a,       32'h0);
      check("postrst_cycles",  32'(cyc),       32'd4);
    end
    idle();

    use_b = 1'b1;
    for (int i = 0; i < 4; i++) run_vec($sformatf("vb%0d", i), vb[i], 2);
    idle();
    @(negedge pclk);
    check("vb_idle_pready", 32'(pready_b), 32'h0);
    check("vb_hold_prdata", prdata_b,      32'h55667788);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
